// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM encoding, PC step and reset PC default.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Clears the byte-offset bits of a redirect target.
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode.
// Entries are {instr, pc}; flush wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [2*XLEN-1:0]       wdata,
    output logic [2*XLEN-1:0]       head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [2*XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_pop;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    assign head   = mem[rd_ptr];

    // Storage, pointers and occupancy update.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Credit accounting upstream must never overfill the buffer.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (reset) !(push && full && !flush)
    );

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one word request at a time,
// buffers responses and hands {instr, pc} to decode.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_t      state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic              drop_q, drop_d;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic [CW-1:0]     cnt_pop;
    logic [2*XLEN-1:0] head;

    assign pop         = instr_valid && instr_ready;
    assign cnt_pop     = count - CW'(pop);
    assign instr_valid = !empty;
    assign instr       = head[2*XLEN-1:XLEN];
    assign instr_pc    = head[XLEN-1:0];
    assign imem_addr   = pc_q;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({imem_rsp_data, req_pc_q}),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Next state, PC, drop flag and request/push strobes.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        req_pc_d       = req_pc_q;
        drop_d         = drop_q;
        imem_req_valid = 1'b0;
        push           = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!full) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    pc_d     = pc_q + PC_STEP;
                    req_pc_d = pc_q;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else begin
                        push = 1'b1;
                    end
                    if ((cnt_pop + CW'(!drop_q)) < DEPTH_C) begin
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirect_valid) begin
            push    = 1'b0;
            pc_d    = redirect_pc & ALIGN_MASK;
            state_d = REQ;
            if (state_q == REQ && imem_req_ready) begin
                drop_d  = 1'b1;
                state_d = WAIT;
            end else if (state_q == WAIT && !imem_rsp_valid) begin
                drop_d  = 1'b1;
                state_d = WAIT;
            end else if (state_q == WAIT) begin
                drop_d = 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic,
// with a PC-stream scoreboard fed at stimulus time.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int checks = 0;
    int errors = 0;
    int n_pops = 0;

    logic [63:0] exp_q[$];

    int  lat_fix = 0;
    bit  lat_rnd = 0;
    bit  keep_on_reset = 0;

    instr_fetch #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
        end
    endtask

    // Expected delivery stream: sequential words from a base PC.
    task automatic load_exp(input logic [31:0] base);
        logic [31:0] p;
        p = base;
        exp_q.delete();
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back({memword(p), p});
            p = p + 32'd4;
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        load_exp(RST_PC);
        repeat (n) next();
        chk("rst_reqv", 64'(imem_req_valid), 64'd0);
        chk("rst_ivalid", 64'(instr_valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_ipc", 64'(instr_pc), 64'd0);
        reset = 1'b0;
    endtask

    // Memory model: one outstanding request, configurable latency.
    logic        m_acc, m_rst, m_pend;
    logic [31:0] m_a, m_paddr;
    int          m_wcnt;
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        m_pend = 1'b0;
        m_wcnt = 0;
        m_paddr = '0;
        forever begin
            @(negedge clk);
            m_acc = imem_req_valid && imem_req_ready && !reset;
            m_a   = imem_addr;
            m_rst = reset;
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (m_rst && !keep_on_reset) m_pend = 1'b0;
            if (m_acc) begin
                if (m_pend) chk("one_outstanding", 64'd1, 64'd0);
                m_pend  = 1'b1;
                m_paddr = m_a;
                m_wcnt  = lat_rnd ? int'($urandom_range(2, 0)) : lat_fix;
            end
            if (m_pend) begin
                if (m_wcnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = memword(m_paddr);
                    m_pend = 1'b0;
                end else begin
                    m_wcnt--;
                end
            end
        end
    end

    // Monitor: pops expected entries on each decode handshake.
    logic        p_stall, p_hold;
    logic [31:0] p_addr;
    logic [63:0] p_head;
    logic [63:0] e;
    initial begin
        p_stall = 1'b0;
        p_hold  = 1'b0;
        p_addr  = '0;
        p_head  = '0;
        forever begin
            @(negedge clk);
            if (p_stall) begin
                chk("addr_stable", {31'd0, imem_req_valid, imem_addr},
                    {31'd0, 1'b1, p_addr});
            end
            if (p_hold) begin
                chk("head_hold", {instr, instr_pc}, p_head);
                chk("valid_hold", 64'(instr_valid), 64'd1);
            end
            if (imem_req_valid) begin
                chk("addr_align", 64'(imem_addr[1:0]), 64'd0);
            end
            if (!reset && !redirect_valid && instr_valid && instr_ready) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    chk("sb_empty", {instr, instr_pc}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", 64'(instr_pc), 64'(e[31:0]));
                    chk("sb_instr", 64'(instr), 64'(e[63:32]));
                end
            end
            p_stall = imem_req_valid && !imem_req_ready
                      && !reset && !redirect_valid;
            p_addr  = imem_addr;
            p_hold  = instr_valid && !instr_ready && !reset && !redirect_valid;
            p_head  = {instr, instr_pc};
        end
    end

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;

        // Steady stream: 3-cycle first latency, then one per 2 cycles.
        do_reset(2);
        for (int c = 0; c < 8; c++) begin
            chk("t1_ivalid", 64'(instr_valid), 64'(c >= 3 && c % 2 == 1));
            chk("t1_reqv", 64'(imem_req_valid), 64'(c % 2 == 1));
            if (c % 2 == 1) chk("t1_addr", 64'(imem_addr), 64'((c - 1) * 2));
            if (c >= 3 && c % 2 == 1)
                chk("t1_ipc", 64'(instr_pc), 64'((c - 3) * 2));
            next();
        end

        // Decode stall for 10 cycles: buffer fills, requests stop.
        instr_ready = 1'b0;
        do_reset(2);
        for (int c = 0; c < 10; c++) begin
            if (c >= 5) begin
                chk("t2_reqv", 64'(imem_req_valid), 64'd0);
                chk("t2_head", {instr, instr_pc}, {memword(32'h0), 32'h0});
            end
            next();
        end
        instr_ready = 1'b1;
        repeat (12) next();

        // Memory not ready for 3 cycles while requesting 0x8.
        do_reset(2);
        repeat (5) next();
        imem_req_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t3_req", {31'd0, imem_req_valid, imem_addr},
                {31'd0, 1'b1, 32'h8});
            next();
        end
        imem_req_ready = 1'b1;
        chk("t3_req_acc", {31'd0, imem_req_valid, imem_addr},
            {31'd0, 1'b1, 32'h8});
        next();
        chk("t3_wait", 64'(imem_req_valid), 64'd0);
        repeat (6) next();

        // Redirect coinciding with acceptance of the 0x8 request.
        do_reset(2);
        repeat (5) next();
        chk("t4_req8", {31'd0, imem_req_valid, imem_addr},
            {31'd0, 1'b1, 32'h8});
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        load_exp(32'h100);
        next();
        redirect_valid = 1'b0;
        chk("t4_flushed", 64'(instr_valid), 64'd0);
        next();
        chk("t4_req100", {31'd0, imem_req_valid, imem_addr},
            {31'd0, 1'b1, 32'h100});
        chk("t4_dropped", 64'(instr_valid), 64'd0);
        repeat (2) next();
        chk("t4_first", {31'd0, instr_valid, instr_pc},
            {31'd0, 1'b1, 32'h100});
        repeat (4) next();

        // Redirect to unaligned 0x203 with a full buffer being popped.
        instr_ready = 1'b0;
        do_reset(2);
        repeat (6) next();
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        load_exp(32'h200);
        next();
        redirect_valid = 1'b0;
        chk("t5_flushed", 64'(instr_valid), 64'd0);
        chk("t5_req200", {31'd0, imem_req_valid, imem_addr},
            {31'd0, 1'b1, 32'h200});
        repeat (6) next();

        // Reset in WAIT with a stale response one cycle later.
        lat_fix = 3;
        keep_on_reset = 1'b1;
        do_reset(2);
        repeat (4) next();
        reset = 1'b1;
        load_exp(RST_PC);
        next();
        reset = 1'b0;
        chk("t6_idle", {62'd0, imem_req_valid, instr_valid}, 64'd0);
        next();
        chk("t6_req0", {31'd0, imem_req_valid, imem_addr},
            {31'd0, 1'b1, RST_PC});
        for (int c = 0; c < 5; c++) begin
            next();
            if (c < 4) chk("t6_stale", 64'(instr_valid), 64'd0);
        end
        chk("t6_first", {31'd0, instr_valid, instr_pc},
            {31'd0, 1'b1, RST_PC});
        next();
        keep_on_reset = 1'b0;
        lat_rnd = 1'b1;

        // Random traffic with redirects, resets and back-pressure.
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(199, 0) == 0);
            imem_req_ready = ($urandom_range(3, 0) != 0);
            instr_ready    = ($urandom_range(3, 0) != 0);
            redirect_valid = !reset && ($urandom_range(24, 0) == 0);
            if (reset) begin
                load_exp(RST_PC);
            end else if (redirect_valid) begin
                if ($urandom_range(9, 0) == 0)
                    redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
                else
                    redirect_pc = $urandom;
                load_exp(redirect_pc & 32'hFFFF_FFFC);
            end
            next();
        end
        reset          = 1'b0;
        redirect_valid = 1'b0;
        repeat (3) next();

        chk("enough_pops", 64'(n_pops > 200), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
